pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage pipeline (fetch, IFID, decode, IDEX, execute, EXMEM, memory, MEMWB, writeBack).
- Detects RAW hazards between the decode-stage source registers and in-flight destinations. The pipeline has no forwarding, so the block stalls the front end until the producer retires.
- Squashes wrong-path instructions after an execute-stage redirect.
- Sequences the halt drain so the pipe empties before `halted` asserts.

Parameters:
- FLUSH_CYCLES, 2, number of cycles the front end is squashed after a redirect (the PC updates through EXMEM).
- DRAIN_CYCLES, 3, cycles from halt leaving ID until it is in MEMWB.
- RF_BYPASS, 0, 1 = register file returns same-cycle write data, so MEMWB destinations are exempt from hazard checks.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (rst=0 resets)
- id_valid  in  1  IFID holds a real instruction
- id_rs  in  3  decode source register 1
- id_rs_used  in  1  rs is read
- id_rt  in  3  decode source register 2
- id_rt_used  in  1  rt is read
- id_halt  in  1  decode sees halt
- idex_writereg  in  3  IDEX destination
- idex_regWrite  in  1  IDEX writes the register file
- exmem_writeReg  in  3  EXMEM destination
- exmem_regWrite  in  1  EXMEM writes the register file
- memwb_writereg  in  3  MEMWB destination
- memwb_regWrite  in  1  MEMWB writes the register file
- ex_redirect  in  1  execute resolved a taken branch or jump
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IFID
- ifid_flush  out  1  load NOP into IFID
- idex_bubble  out  1  zero IDEX control (regWrite, memWrite, memRead, branch, jump, halt)
- halted  out  1  pipe drained after halt
- err  out  1  illegal condition, sticky
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- Reset (rst=0, async): FSM=RUN, flush_cnt=0, drain_cnt=0, stall_count=0, err=0; all outputs 0.
- raw_hit = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
  - match(r) = (idex_regWrite & idex_writereg==r) | (exmem_regWrite & exmem_writeReg==r) | (!RF_BYPASS & memwb_regWrite & memwb_writereg==r).
  - r0 is a real register; there is no zero-register exemption.
- flushing = ex_redirect | (flush_cnt!=0).
- FSM states:
  - RUN
    - ex_redirect: flush_cnt <= FLUSH_CYCLES-1; ifid_flush=1, idex_bubble=1.
    - Else flush_cnt!=0: ifid_flush=1, idex_bubble=1, flush_cnt decrements.
    - Else raw_hit: pc_stall=1, ifid_stall=1, idex_bubble=1.
    - Else id_valid & id_halt: go to DRAIN, drain_cnt <= DRAIN_CYCLES-1, pc_stall=1, ifid_stall=1; the halt itself passes into IDEX (no bubble).
    - Priority is redirect > flush window > RAW stall > halt. A halt in ID during a redirect or flush cycle is squashed, not honoured.
  - DRAIN
    - pc_stall=1, ifid_stall=1, idex_bubble=1 every cycle.
    - drain_cnt decrements; at 0 go to HALTED.
    - ex_redirect during DRAIN is ignored.
  - HALTED
    - halted=1, pc_stall=1, ifid_stall=1, idex_bubble=1.
    - Only reset exits this state.
- Stall and flush signals are combinational from registered state plus current inputs, with zero latency. halted is registered and asserts DRAIN_CYCLES cycles after the halt decode cycle.
- stall_count increments on every cycle with pc_stall=1 in RUN, saturating at 16'hFFFF; no wrap.
- err is set on either:
  - ex_redirect while flush_cnt!=0 (a squashed instruction redirected);
  - FSM reaching an illegal encoding (FSM then forces HALTED).
- err is cleared only by reset.
- Reset mid-flush or mid-drain returns to RUN immediately; counters clear.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state encodings RUN=2'b00, DRAIN=2'b01, HALTED=2'b10;
  - REG_W=3; NOP control constants used by the bubble logic in IDEX.
- One sub-module, `raw_compare`: combinational 3-destination comparator for one source register. Instantiated twice, for rs and rt.

Test Plan:
- Writer r3 in IDEX (idex_regWrite=1, idex_writereg=3); ID reads rs=3 with id_rs_used=1 → pc_stall=ifid_stall=idex_bubble=1 for 3 cycles as r3 moves IDEX→EXMEM→MEMWB. Releases on the 4th cycle with RF_BYPASS=0, or the 3rd with RF_BYPASS=1. stall_count=3 (or 2).
- id_rt=5 with id_rt_used=0, writer r5 in EXMEM → no stall.
- ex_redirect pulse for 1 cycle → ifid_flush=idex_bubble=1 for exactly 2 cycles; a RAW hit present in the same cycles produces no pc_stall.
- id_halt=1, id_valid=1, no hazards → DRAIN; halted=1 exactly 3 cycles later, and stays 1 under ex_redirect pulses.
- id_halt coincident with ex_redirect → stays RUN, halted never asserts; a second ex_redirect on the next cycle (flush_cnt=1) → err=1, sticky.
- Drive 70000 forced stall cycles → stall_count saturates at 16'hFFFF; assert rst=0 mid-DRAIN → all outputs 0 asynchronously, FSM=RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/flush/halt sequencer.
//   ctrl_state_t : sequencer FSM encodings (RUN / DRAIN / HALTED)
//   REG_W        : register-file index width
//   idex_ctrl_t  : the IDEX control bundle that a bubble zeroes
//   NOP_CTRL     : all-zero control word loaded into IDEX on a bubble
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } ctrl_state_t;

    // Control fields that carry side effects out of IDEX; a bubble clears all.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic branch;
        logic jump;
        logic halt;
    } idex_ctrl_t;

    localparam idex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/raw_compare.sv
// -----------------------------------------------------------------------------
// raw_compare
// Combinational check of one decode-stage source register against the three
// in-flight destinations (IDEX, EXMEM, MEMWB).
//   src            : source register read in decode
//   idex_*         : IDEX destination and its write enable
//   exmem_*        : EXMEM destination and its write enable
//   memwb_*        : MEMWB destination and its write enable
//   hit            : some in-flight producer still owes this register
// r0 is an ordinary register here, so it gets no exemption.
// -----------------------------------------------------------------------------
module raw_compare
    import pipe_ctrl_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b0
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] idex_writereg,
    input  logic             idex_regWrite,
    input  logic [REG_W-1:0] exmem_writeReg,
    input  logic             exmem_regWrite,
    input  logic [REG_W-1:0] memwb_writereg,
    input  logic             memwb_regWrite,
    output logic             hit
);

    logic memwb_hit;

    // With a write-through register file the MEMWB producer lands in the
    // same cycle the decode read happens, so it never needs a stall.
    assign memwb_hit = !RF_BYPASS && memwb_regWrite && (memwb_writereg == src);

    assign hit = (idex_regWrite  && (idex_writereg  == src)) ||
                 (exmem_regWrite && (exmem_writeReg == src)) ||
                 memwb_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall / flush / halt sequencer for the 5-stage pipeline (no forwarding).
//   clk, rst       : clock, asynchronous active-low reset
//   id_*           : decode-stage instruction (valid, sources, halt)
//   idex_/exmem_/memwb_* : in-flight destinations and write enables
//   ex_redirect    : execute resolved a taken branch or jump
//   pc_stall, ifid_stall : hold the front end
//   ifid_flush     : load a NOP into IFID
//   idex_bubble    : load NOP_CTRL into IDEX
//   halted         : pipe fully drained after a halt
//   err            : sticky illegal-condition flag
//   stall_count    : saturating count of RUN-state stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter bit RF_BYPASS    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic             id_halt,
    input  logic [REG_W-1:0] idex_writereg,
    input  logic             idex_regWrite,
    input  logic [REG_W-1:0] exmem_writeReg,
    input  logic             exmem_regWrite,
    input  logic [REG_W-1:0] memwb_writereg,
    input  logic             memwb_regWrite,
    input  logic             ex_redirect,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic             err,
    output logic [15:0]      stall_count
);

    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    ctrl_state_t state, state_next;
    logic [7:0]  flush_cnt, flush_next;
    logic [7:0]  drain_cnt, drain_next;
    logic [15:0] stall_next;
    logic        err_next;
    logic        illegal_state;
    logic        rs_hit, rt_hit, raw_hit;
    logic        pc_stall_c, ifid_stall_c, ifid_flush_c, idex_bubble_c;

    raw_compare #(.RF_BYPASS(RF_BYPASS)) u_rs_cmp (
        .src            (id_rs),
        .idex_writereg  (idex_writereg),
        .idex_regWrite  (idex_regWrite),
        .exmem_writeReg (exmem_writeReg),
        .exmem_regWrite (exmem_regWrite),
        .memwb_writereg (memwb_writereg),
        .memwb_regWrite (memwb_regWrite),
        .hit            (rs_hit)
    );

    raw_compare #(.RF_BYPASS(RF_BYPASS)) u_rt_cmp (
        .src            (id_rt),
        .idex_writereg  (idex_writereg),
        .idex_regWrite  (idex_regWrite),
        .exmem_writeReg (exmem_writeReg),
        .exmem_regWrite (exmem_regWrite),
        .memwb_writereg (memwb_writereg),
        .memwb_regWrite (memwb_regWrite),
        .hit            (rt_hit)
    );

    assign raw_hit = id_valid && ((id_rs_used && rs_hit) || (id_rt_used && rt_hit));

    // Next-state and front-end controls. Priority in RUN is redirect, then the
    // remainder of the flush window, then RAW stall, then halt, so a halt that
    // sits on the wrong path is squashed instead of honoured. DRAIN ends on
    // the cycle the counter would decrement to zero, which puts HALTED exactly
    // DRAIN_CYCLES cycles after the halt was decoded.
    always_comb begin
        state_next    = state;
        flush_next    = flush_cnt;
        drain_next    = drain_cnt;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        illegal_state = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_redirect) begin
                    flush_next    = FLUSH_LOAD;
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (flush_cnt != 8'd0) begin
                    flush_next    = flush_cnt - 8'd1;
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (raw_hit) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (id_valid && id_halt) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    drain_next    = DRAIN_LOAD;
                    state_next    = (DRAIN_CYCLES <= 1) ? ST_HALTED : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idex_bubble_c = 1'b1;
                if (drain_cnt <= 8'd1) begin
                    drain_next = 8'd0;
                    state_next = ST_HALTED;
                end else begin
                    drain_next = drain_cnt - 8'd1;
                end
            end
            ST_HALTED: begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idex_bubble_c = 1'b1;
            end
            default: begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idex_bubble_c = 1'b1;
                illegal_state = 1'b1;
                state_next    = ST_HALTED;
            end
        endcase
    end

    // Sticky error and saturating stall counter. Only RUN stalls are counted;
    // the permanent stall of DRAIN/HALTED would otherwise swamp the statistic.
    always_comb begin
        err_next   = err || illegal_state || (ex_redirect && (flush_cnt != 8'd0));
        stall_next = stall_count;
        if ((state == ST_RUN) && pc_stall_c && (stall_count != 16'hFFFF)) begin
            stall_next = stall_count + 16'd1;
        end
    end

    // State and counter registers; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            flush_cnt   <= 8'd0;
            drain_cnt   <= 8'd0;
            stall_count <= 16'd0;
            err         <= 1'b0;
        end else begin
            state       <= state_next;
            flush_cnt   <= flush_next;
            drain_cnt   <= drain_next;
            stall_count <= stall_next;
            err         <= err_next;
        end
    end

    // Combinational controls are gated by reset so every output reads zero
    // while reset is held, whatever the pipeline inputs are doing.
    assign pc_stall    = rst && pc_stall_c;
    assign ifid_stall  = rst && ifid_stall_c;
    assign ifid_flush  = rst && ifid_flush_c;
    assign idex_bubble = rst && idex_bubble_c;
    assign halted      = (state == ST_HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scoreboard bench for pipe_hazard_ctrl (default parameters).
// Stimulus is driven 1 time unit after each rising edge together with the
// hand-computed expected outputs for that cycle; the monitor samples on the
// falling edge and compares against the queued expectation.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [2:0] id_rs;
        logic       id_rs_used;
        logic [2:0] id_rt;
        logic       id_rt_used;
        logic       id_halt;
        logic [2:0] idex_wr;
        logic       idex_we;
        logic [2:0] exmem_wr;
        logic       exmem_we;
        logic [2:0] memwb_wr;
        logic       memwb_we;
        logic       redirect;
    } stim_t;

    // flags = {pc_stall, ifid_stall, ifid_flush, idex_bubble, halted, err}
    typedef struct {
        logic [5:0]  flags;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_rs = '0;
    logic        id_rs_used = 1'b0;
    logic [2:0]  id_rt = '0;
    logic        id_rt_used = 1'b0;
    logic        id_halt = 1'b0;
    logic [2:0]  idex_writereg = '0;
    logic        idex_regWrite = 1'b0;
    logic [2:0]  exmem_writeReg = '0;
    logic        exmem_regWrite = 1'b0;
    logic [2:0]  memwb_writereg = '0;
    logic        memwb_regWrite = 1'b0;
    logic        ex_redirect = 1'b0;
    logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, halted, err;
    logic [15:0] stall_count;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .id_rt          (id_rt),
        .id_rt_used     (id_rt_used),
        .id_halt        (id_halt),
        .idex_writereg  (idex_writereg),
        .idex_regWrite  (idex_regWrite),
        .exmem_writeReg (exmem_writeReg),
        .exmem_regWrite (exmem_regWrite),
        .memwb_writereg (memwb_writereg),
        .memwb_regWrite (memwb_regWrite),
        .ex_redirect    (ex_redirect),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .halted         (halted),
        .err            (err),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Decode reads rs=3 while the given stage (0=IDEX,1=EXMEM,2=MEMWB,3=none) writes r3.
    function automatic stim_t rawR3(input int stage);
        stim_t s;
        s            = idle();
        s.id_valid   = 1'b1;
        s.id_rs      = 3'd3;
        s.id_rs_used = 1'b1;
        if (stage == 0) begin s.idex_wr  = 3'd3; s.idex_we  = 1'b1; end
        if (stage == 1) begin s.exmem_wr = 3'd3; s.exmem_we = 1'b1; end
        if (stage == 2) begin s.memwb_wr = 3'd3; s.memwb_we = 1'b1; end
        return s;
    endfunction

    function automatic exp_t mk(input logic [5:0] flags, input logic [15:0] cnt, input string name);
        exp_t e;
        e.flags = flags;
        e.cnt   = cnt;
        e.name  = name;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst            = s.rst;
        id_valid       = s.id_valid;
        id_rs          = s.id_rs;
        id_rs_used     = s.id_rs_used;
        id_rt          = s.id_rt;
        id_rt_used     = s.id_rt_used;
        id_halt        = s.id_halt;
        idex_writereg  = s.idex_wr;
        idex_regWrite  = s.idex_we;
        exmem_writeReg = s.exmem_wr;
        exmem_regWrite = s.exmem_we;
        memwb_writereg = s.memwb_wr;
        memwb_regWrite = s.memwb_we;
        ex_redirect    = s.redirect;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] got;
        got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, halted, err};
        checks++;
        if (got !== e.flags) begin
            fails++;
            $display("[TB] FAIL %s flags got=%b want=%b (pc,ifs,iff,bub,hlt,err)", e.name, got, e.flags);
        end
        checks++;
        if (stall_count !== e.cnt) begin
            fails++;
            $display("[TB] FAIL %s stall_count got=%0d want=%0d", e.name, stall_count, e.cnt);
        end
    endtask

    // Monitor: every falling edge with an outstanding expectation is compared.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        stim_t s;
        int    waited;

        $display("[TB] start");

        // Reset holds every output low even with a live hazard on the inputs.
        s = idle(); s.rst = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd0, "reset_idle"));
        s = rawR3(0); s.rst = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd0, "reset_gate"));
        applyStimulus(idle(), mk(6'b000000, 16'd0, "reset_release"));

        // Producer r3 walks IDEX -> EXMEM -> MEMWB, released on the fourth cycle.
        applyStimulus(rawR3(0), mk(6'b110100, 16'd0, "raw_idex"));
        applyStimulus(rawR3(1), mk(6'b110100, 16'd1, "raw_exmem"));
        applyStimulus(rawR3(2), mk(6'b110100, 16'd2, "raw_memwb"));
        applyStimulus(rawR3(3), mk(6'b000000, 16'd3, "raw_release"));

        // r0 is a real register.
        s = rawR3(0); s.id_rs = 3'd0; s.idex_wr = 3'd0;
        applyStimulus(s, mk(6'b110100, 16'd3, "raw_r0"));

        // rt matches EXMEM but is not read, then is read.
        s = idle(); s.id_valid = 1'b1; s.id_rt = 3'd5; s.exmem_wr = 3'd5; s.exmem_we = 1'b1;
        applyStimulus(s, mk(6'b000000, 16'd4, "rt_unused"));
        s.id_rt_used = 1'b1;
        applyStimulus(s, mk(6'b110100, 16'd4, "rt_used"));

        // Matching register without a write enable, and a near-miss register.
        s = rawR3(0); s.idex_we = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd5, "no_regwrite"));
        s = rawR3(0); s.id_rs = 3'd5; s.idex_wr = 3'd4;
        applyStimulus(s, mk(6'b000000, 16'd5, "reg_mismatch"));

        // MEMWB producer still stalls without bypass; invalid decode never stalls.
        s = idle(); s.id_valid = 1'b1; s.id_rt = 3'd2; s.id_rt_used = 1'b1;
        s.memwb_wr = 3'd2; s.memwb_we = 1'b1;
        applyStimulus(s, mk(6'b110100, 16'd5, "rt_memwb"));
        s = rawR3(0); s.id_valid = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd6, "id_invalid"));

        // Redirect: two flush cycles that override a concurrent RAW hit.
        s = rawR3(0); s.redirect = 1'b1;
        applyStimulus(s, mk(6'b001100, 16'd6, "redirect"));
        applyStimulus(rawR3(0), mk(6'b001100, 16'd6, "flush_window"));
        applyStimulus(rawR3(0), mk(6'b110100, 16'd6, "flush_done_raw"));
        applyStimulus(idle(), mk(6'b000000, 16'd7, "after_flush"));

        // Halt under a redirect is squashed; a redirect inside the window is an error.
        s = idle(); s.id_valid = 1'b1; s.id_halt = 1'b1; s.redirect = 1'b1;
        applyStimulus(s, mk(6'b001100, 16'd7, "halt_squashed"));
        s = idle(); s.redirect = 1'b1;
        applyStimulus(s, mk(6'b001100, 16'd7, "redirect_in_flush"));
        applyStimulus(idle(), mk(6'b001101, 16'd7, "err_set"));
        applyStimulus(idle(), mk(6'b000001, 16'd7, "err_sticky"));
        applyStimulus(idle(), mk(6'b000001, 16'd7, "err_no_halt"));

        s = idle(); s.rst = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd0, "reset_clears_err"));
        applyStimulus(idle(), mk(6'b000000, 16'd0, "run_after_reset"));

        // Halt drain: halted three cycles after decode, redirects ignored.
        s = idle(); s.id_valid = 1'b1; s.id_halt = 1'b1;
        applyStimulus(s, mk(6'b110000, 16'd0, "halt_decode"));
        s = idle(); s.redirect = 1'b1;
        applyStimulus(s, mk(6'b110100, 16'd1, "drain_1_redirect"));
        applyStimulus(idle(), mk(6'b110100, 16'd1, "drain_2"));
        applyStimulus(idle(), mk(6'b110110, 16'd1, "halted"));
        s = idle(); s.redirect = 1'b1;
        applyStimulus(s, mk(6'b110110, 16'd1, "halted_redirect"));
        applyStimulus(s, mk(6'b110110, 16'd1, "halted_redirect2"));
        applyStimulus(idle(), mk(6'b110110, 16'd1, "halted_hold"));

        s = idle(); s.rst = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd0, "reset_from_halted"));

        // Long stall to saturate the counter.
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(rawR3(0), mk(6'b110100, (i < 65535) ? 16'(i) : 16'hFFFF, "saturate"));
        end
        applyStimulus(idle(), mk(6'b000000, 16'hFFFF, "sat_hold"));

        // Enter DRAIN and reset in the middle of it.
        s = idle(); s.id_valid = 1'b1; s.id_halt = 1'b1;
        applyStimulus(s, mk(6'b110000, 16'hFFFF, "sat_halt"));
        applyStimulus(idle(), mk(6'b110100, 16'hFFFF, "sat_drain"));
        s = idle(); s.rst = 1'b0;
        applyStimulus(s, mk(6'b000000, 16'd0, "reset_mid_drain"));
        applyStimulus(rawR3(0), mk(6'b110100, 16'd0, "run_after_drain_reset"));
        applyStimulus(idle(), mk(6'b000000, 16'd1, "final_idle"));

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            fails++;
            $display("[TB] FAIL drain_queue pending=%0d want=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
